// File: rtl/append_pkg.sv
// Shared definitions for the append_gate ripple-carry adder.
// Holds the width limit and the golden sum used by checks.
`timescale 1ns/1ps
package append_pkg;

    localparam int APPEND_MAX_WIDTH = 64;

    typedef logic [APPEND_MAX_WIDTH:0] append_sum_t;

    // Inputs are zero-extended, so the low WIDTH+1 bits hold the exact sum.
    function automatic append_sum_t append_ref(
        input logic [APPEND_MAX_WIDTH-1:0] a,
        input logic [APPEND_MAX_WIDTH-1:0] b,
        input logic                        c
    );
        return append_sum_t'(a) + append_sum_t'(b) + append_sum_t'(c);
    endfunction

endpackage

// File: rtl/append_gate_full_adder_cell.sv
// One-bit full-adder cell, the leaf of the ripple chain.
// Purely combinational.
`timescale 1ns/1ps
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/append_gate.sv
// WIDTH-bit ripple-carry adder, {Co,S} = A + B + C.
// Optional output register on ck, async-cleared by rst_n.
`timescale 1ns/1ps
module append_gate
    import append_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    if (WIDTH < 1 || WIDTH > APPEND_MAX_WIDTH) begin : g_bad_width
        $error("append_gate: WIDTH %0d outside 1..%0d",
               WIDTH, APPEND_MAX_WIDTH);
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = C;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic             co_q;

        always_ff @(posedge ck or negedge rst_n) begin
            if (!rst_n) begin
                s_q  <= '0;
                co_q <= 1'b0;
            end else begin
                s_q  <= sum;
                co_q <= carry[WIDTH];
            end
        end

        assign S  = s_q;
        assign Co = co_q;
    end else begin : g_comb
        // Clock and reset are unused here; left dangling on purpose.
        logic unused_clk;
        assign unused_clk = ck ^ rst_n;

        assign S  = sum;
        assign Co = carry[WIDTH];
    end

endmodule

// File: tb/tb_append_gate.sv
// Bench for append_gate: directed vectors plus a random
// scoreboard across widths 1/8/33/64, combinational and registered.
`timescale 1ns/1ps
module tb_append_gate;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] va;
    logic [63:0] vb;
    logic        vc;

    logic [0:0]  s1c, s1r;
    logic [7:0]  s8c, s8r;
    logic [32:0] s33c, s33r;
    logic [63:0] s64c, s64r;
    logic        co1c, co1r, co8c, co8r;
    logic        co33c, co33r, co64c, co64r;

    int nvec = 0;
    int nbad = 0;

    logic [64:0] q1[$];
    logic [64:0] q8[$];
    logic [64:0] q33[$];
    logic [64:0] q64[$];

    always #100 ck = ~ck;

    append_gate #(.WIDTH(1), .REG_OUT(0)) u_c1 (
        .ck(ck), .rst_n(rst_n), .A(va[0:0]), .B(vb[0:0]), .C(vc),
        .S(s1c), .Co(co1c));
    append_gate #(.WIDTH(1), .REG_OUT(1)) u_r1 (
        .ck(ck), .rst_n(rst_n), .A(va[0:0]), .B(vb[0:0]), .C(vc),
        .S(s1r), .Co(co1r));
    append_gate #(.WIDTH(8), .REG_OUT(0)) u_c8 (
        .ck(ck), .rst_n(rst_n), .A(va[7:0]), .B(vb[7:0]), .C(vc),
        .S(s8c), .Co(co8c));
    append_gate #(.WIDTH(8), .REG_OUT(1)) u_r8 (
        .ck(ck), .rst_n(rst_n), .A(va[7:0]), .B(vb[7:0]), .C(vc),
        .S(s8r), .Co(co8r));
    append_gate #(.WIDTH(33), .REG_OUT(0)) u_c33 (
        .ck(ck), .rst_n(rst_n), .A(va[32:0]), .B(vb[32:0]), .C(vc),
        .S(s33c), .Co(co33c));
    append_gate #(.WIDTH(33), .REG_OUT(1)) u_r33 (
        .ck(ck), .rst_n(rst_n), .A(va[32:0]), .B(vb[32:0]), .C(vc),
        .S(s33r), .Co(co33r));
    append_gate #(.WIDTH(64), .REG_OUT(0)) u_c64 (
        .ck(ck), .rst_n(rst_n), .A(va), .B(vb), .C(vc),
        .S(s64c), .Co(co64c));
    append_gate #(.WIDTH(64), .REG_OUT(1)) u_r64 (
        .ck(ck), .rst_n(rst_n), .A(va), .B(vb), .C(vc),
        .S(s64r), .Co(co64r));

    task automatic check(input string tag,
                         input logic [64:0] obs,
                         input logic [64:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Independent model: mask operands to w bits, add, keep w+1 bits.
    function automatic logic [64:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic c,
                                          input int w);
        logic [65:0] m;
        logic [65:0] r;
        m = (66'd1 << w) - 66'd1;
        r = {2'b00, a & m[63:0]} + {2'b00, b & m[63:0]} + {65'd0, c};
        m = (66'd1 << (w + 1)) - 66'd1;
        r = r & m;
        return r[64:0];
    endfunction

    task automatic cycle(input logic [63:0] a,
                         input logic [63:0] b,
                         input logic c);
        @(negedge ck);
        va = a;
        vb = b;
        vc = c;
        q1.push_back(model(a, b, c, 1));
        q8.push_back(model(a, b, c, 8));
        q33.push_back(model(a, b, c, 33));
        q64.push_back(model(a, b, c, 64));
        #1;
        check("c1",  65'({co1c, s1c}),   model(a, b, c, 1));
        check("c8",  65'({co8c, s8c}),   model(a, b, c, 8));
        check("c33", 65'({co33c, s33c}), model(a, b, c, 33));
        check("c64", 65'({co64c, s64c}), model(a, b, c, 64));
        @(posedge ck);
        #1;
        check("r1",  65'({co1r, s1r}),   q1.pop_front());
        check("r8",  65'({co8r, s8r}),   q8.pop_front());
        check("r33", 65'({co33r, s33r}), q33.pop_front());
        check("r64", 65'({co64r, s64r}), q64.pop_front());
    endtask

    logic [1:0] tt [8];
    logic [2:0] v3;

    initial begin
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        va = '1;
        vb = '1;
        vc = 1'b1;
        #1;
        check("rst_r8",  65'({co8r, s8r}),   65'd0);
        check("rst_r64", 65'({co64r, s64r}), 65'd0);

        // Classic 1-bit full adder truth table, 100 ns per vector
        va = '0;
        vb = '0;
        for (int i = 0; i < 8; i++) begin
            v3 = 3'(i);
            va[0] = v3[2];
            vb[0] = v3[1];
            vc    = v3[0];
            #50;
            check($sformatf("fa%0d", i), 65'({co1c, s1c}), 65'(tt[i]));
            #50;
        end
        check("rst_hold_r1", 65'({co1r, s1r}), 65'd0);

        va = 64'hFF; vb = 64'h00; vc = 1'b1;
        #10 check("w8_ff_00_1", 65'({co8c, s8c}), 65'h100);
        va = 64'h7F; vb = 64'h01; vc = 1'b0;
        #10 check("w8_7f_01_0", 65'({co8c, s8c}), 65'h080);
        va = 64'hFF; vb = 64'hFF; vc = 1'b1;
        #10 check("w8_ff_ff_1", 65'({co8c, s8c}), 65'h1FF);
        check("rst_hold_r8", 65'({co8r, s8r}), 65'd0);

        @(negedge ck);
        rst_n = 1'b1;
        cycle(64'd0, 64'd0, 1'b0);

        // One-cycle latency: new value only after the edge
        @(negedge ck);
        va = 64'h12; vb = 64'h34; vc = 1'b1;
        #1 check("lat_pre", 65'({co8r, s8r}), 65'd0);
        @(posedge ck);
        #1 check("lat_post", 65'({co8r, s8r}), 65'h047);

        cycle(64'hF0, 64'h20, 1'b0);
        check("ld_f0_20", 65'({co8r, s8r}), 65'h110);
        @(negedge ck);
        #20 rst_n = 1'b0;
        #1;
        check("arst_r8",  65'({co8r, s8r}),   65'd0);
        check("arst_r64", 65'({co64r, s64r}), 65'd0);
        repeat (2) begin
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            vc = 1'($urandom_range(0, 1));
            @(posedge ck);
            #1;
            check("inrst_r8",  65'({co8r, s8r}),   65'd0);
            check("inrst_r33", 65'({co33r, s33r}), 65'd0);
        end
        @(negedge ck);
        rst_n = 1'b1;
        va = 64'h05; vb = 64'h06; vc = 1'b1;
        #1 check("rel_pre", 65'({co8r, s8r}), 65'd0);
        @(posedge ck);
        #1 check("rel_post", 65'({co8r, s8r}), 65'h00C);

        cycle('1, '1, 1'b1);
        cycle('1, 64'd0, 1'b1);
        cycle(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        cycle(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        cycle(64'd0, 64'd0, 1'b1);

        repeat (10000) begin
            cycle({$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
